// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: slave register map, FSM state
// encoding, CONTROL bit positions and direction/mode encodings.
package led_seq_pkg;

   // Slave register addresses
   localparam logic [1:0] REG_CONTROL = 2'd0;
   localparam logic [1:0] REG_PERIOD  = 2'd1;
   localparam logic [1:0] REG_PATTERN = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   // CONTROL register bit indices
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;

   // Shift direction and sequencing mode encodings
   localparam logic DIR_LEFT    = 1'b0;
   localparam logic DIR_RIGHT   = 1'b1;
   localparam logic MODE_BOUNCE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TICK  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/led_seq_next.sv
// Next-pattern logic for the LED sequencer (purely combinational).
// Ports:
//   pattern      current LED pattern
//   dir          current bounce direction (DIR_LEFT / DIR_RIGHT)
//   mode         0 = rotate-left, 1 = bounce
//   next_pattern pattern for the next step
//   next_dir     direction for the next step
module led_seq_next
   import led_seq_pkg::*;
#(
   parameter int WIDTH = 26
) (
   input  logic [WIDTH-1:0] pattern,
   input  logic             dir,
   input  logic             mode,
   output logic [WIDTH-1:0] next_pattern,
   output logic             next_dir
);

   always_comb begin
      next_pattern = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
      next_dir     = dir;
      if (mode == MODE_BOUNCE) begin
         // Reaching an edge reverses direction and the step is taken in the
         // new direction, so the lit bit never falls off the end.
         if (dir == DIR_LEFT) begin
            if (pattern[WIDTH-1]) begin
               next_dir     = DIR_RIGHT;
               next_pattern = pattern >> 1;
            end else begin
               next_pattern = pattern << 1;
            end
         end else begin
            if (pattern[0]) begin
               next_dir     = DIR_LEFT;
               next_pattern = pattern << 1;
            end else begin
               next_pattern = pattern >> 1;
            end
         end
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// Autonomous LED pattern engine. A CPU configures it through an Avalon-MM
// slave; an Avalon-MM master writes each new pattern to PIO address 0.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   s_address/s_chipselect/s_write_n/s_writedata/s_readdata
//                               configuration slave (zero wait states)
//   m_address/m_chipselect/m_write_n/m_writedata/m_waitrequest
//                               master port toward the LED PIO
//   step_pulse                  high in the cycle a master write is accepted
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int          WIDTH      = 26,
   parameter logic [31:0] PERIOD_RST = 32'd50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        step_pulse
);

   localparam int PAD = 32 - WIDTH;

   state_t           state;
   logic             en;
   logic             mode;
   logic             dir;
   logic             pend;
   logic [31:0]      period;
   logic [31:0]      cnt;
   logic [31:0]      reload;
   logic [15:0]      step_cnt;
   logic [WIDTH-1:0] pattern;
   logic [WIDTH-1:0] nxt_pattern;
   logic             nxt_dir;
   logic             s_wr;
   logic             pat_wr;
   logic             accept;
   logic [31:0]      new_word;

   assign s_wr     = s_chipselect & ~s_write_n;
   assign pat_wr   = s_wr && (s_address == REG_PATTERN);
   assign accept   = m_chipselect & ~m_waitrequest;
   assign new_word = {{PAD{1'b0}}, s_writedata[WIDTH-1:0]};
   // A period of 0 behaves like 1: the counter always spends at least one
   // cycle in TICK.
   assign reload   = (period == 32'd0) ? 32'd0 : period - 32'd1;

   assign m_address  = 2'b00;
   assign step_pulse = accept;

   led_seq_next #(.WIDTH(WIDTH)) u_next (
      .pattern      (pattern),
      .dir          (dir),
      .mode         (mode),
      .next_pattern (nxt_pattern),
      .next_dir     (nxt_dir)
   );

   // Configuration registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en     <= 1'b0;
         mode   <= 1'b0;
         period <= PERIOD_RST;
      end else if (s_wr) begin
         if (s_address == REG_CONTROL) begin
            en   <= s_writedata[CTRL_EN];
            mode <= s_writedata[CTRL_MODE];
         end
         if (s_address == REG_PERIOD) begin
            period <= s_writedata;
         end
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         REG_CONTROL: s_readdata = {30'd0, mode, en};
         REG_PERIOD:  s_readdata = period;
         REG_PATTERN: s_readdata = {{PAD{1'b0}}, pattern};
         REG_STATUS:  s_readdata = {step_cnt, 15'd0, (state != ST_IDLE)};
         default:     s_readdata = '0;
      endcase
   end

   // Sequencer FSM with registered master outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         pattern      <= '0;
         dir          <= DIR_LEFT;
         pend         <= 1'b0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
         step_cnt     <= '0;
      end else begin
         if (accept) begin
            step_cnt <= step_cnt + 16'd1;
         end
         if (pat_wr) begin
            pattern <= s_writedata[WIDTH-1:0];
            dir     <= DIR_LEFT;
         end
         case (state)
            ST_IDLE, ST_TICK: begin
               if (pat_wr) begin
                  state        <= ST_WRITE;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= new_word;
                  pend         <= 1'b0;
               end else if (state == ST_IDLE) begin
                  if (en) begin
                     cnt   <= reload;
                     state <= ST_TICK;
                  end
               end else if (!en) begin
                  state <= ST_IDLE;
               end else if (cnt == 32'd0) begin
                  pattern      <= nxt_pattern;
                  dir          <= nxt_dir;
                  state        <= ST_WRITE;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{PAD{1'b0}}, nxt_pattern};
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            ST_WRITE: begin
               if (accept) begin
                  // A pattern loaded while the transfer was in flight gets
                  // its own transfer straight after the current one.
                  if (pat_wr) begin
                     m_writedata <= new_word;
                     pend        <= 1'b0;
                  end else if (pend) begin
                     m_writedata <= {{PAD{1'b0}}, pattern};
                     pend        <= 1'b0;
                  end else begin
                     m_chipselect <= 1'b0;
                     m_write_n    <= 1'b1;
                     if (en) begin
                        cnt   <= reload;
                        state <= ST_TICK;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end else if (pat_wr) begin
                  pend <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer and its led_seq_next sub-module.
module tb_led_sequencer;
   import led_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  s_address = 2'd0;
   logic        s_chipselect = 1'b0;
   logic        s_write_n = 1'b1;
   logic [31:0] s_writedata = 32'd0;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b0;
   logic        step_pulse;

   // Standalone next-pattern instance
   logic [25:0] n_pat = 26'd0;
   logic        n_dir = 1'b0;
   logic        n_mode = 1'b0;
   logic [25:0] n_next_pat;
   logic        n_next_dir;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int wr_total = 0;
   logic [31:0] wr_data[$];
   int          wr_cyc[$];

   always #5 clk = ~clk;

   led_sequencer #(.WIDTH(26), .PERIOD_RST(32'd50000000)) dut (
      .clk           (clk),
      .reset         (reset),
      .s_address     (s_address),
      .s_chipselect  (s_chipselect),
      .s_write_n     (s_write_n),
      .s_writedata   (s_writedata),
      .s_readdata    (s_readdata),
      .m_address     (m_address),
      .m_chipselect  (m_chipselect),
      .m_write_n     (m_write_n),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest),
      .step_pulse    (step_pulse)
   );

   led_seq_next #(.WIDTH(26)) u_next (
      .pattern      (n_pat),
      .dir          (n_dir),
      .mode         (n_mode),
      .next_pattern (n_next_pat),
      .next_dir     (n_next_dir)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Log every accepted master write
   always @(posedge clk) begin
      if (m_chipselect && !m_write_n && !m_waitrequest) begin
         wr_data.push_back(m_writedata);
         wr_cyc.push_back(cyc);
         wr_total = wr_total + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      s_address    = a;
      s_writedata  = d;
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      s_address    = a;
      s_chipselect = 1'b1;
      s_write_n    = 1'b1;
      #1;
      d = s_readdata;
      s_chipselect = 1'b0;
   endtask

   task automatic wait_writes(input string name, input int n, input int budget);
      int k = 0;
      while (wr_data.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(name, wr_data.size(), n);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   typedef struct packed {
      logic [25:0] pat;
      logic        dir;
      logic        mode;
      logic [25:0] exp_pat;
      logic        exp_dir;
   } nvec_t;

   typedef struct packed {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } rvec_t;

   nvec_t nv[10];
   rvec_t rv[6];

   initial begin
      logic [31:0] rd;
      logic [31:0] sc0;
      int          k;

      // Next-pattern vectors: {pattern, dir, mode, expected pattern, expected dir}
      nv[0] = '{26'h0000001, DIR_LEFT,  1'b0, 26'h0000002, DIR_LEFT};
      nv[1] = '{26'h2000000, DIR_LEFT,  1'b0, 26'h0000001, DIR_LEFT};
      nv[2] = '{26'h2000001, DIR_RIGHT, 1'b0, 26'h0000003, DIR_RIGHT};
      nv[3] = '{26'h0000000, DIR_LEFT,  1'b0, 26'h0000000, DIR_LEFT};
      nv[4] = '{26'h0000000, DIR_LEFT,  1'b1, 26'h0000000, DIR_LEFT};
      nv[5] = '{26'h1000000, DIR_LEFT,  1'b1, 26'h2000000, DIR_LEFT};
      nv[6] = '{26'h2000000, DIR_LEFT,  1'b1, 26'h1000000, DIR_RIGHT};
      nv[7] = '{26'h0000002, DIR_RIGHT, 1'b1, 26'h0000001, DIR_RIGHT};
      nv[8] = '{26'h0000001, DIR_RIGHT, 1'b1, 26'h0000002, DIR_LEFT};
      nv[9] = '{26'h3000000, DIR_LEFT,  1'b1, 26'h1800000, DIR_RIGHT};

      // Register vectors: {address, write data, expected readback}
      rv[0] = '{REG_PERIOD,  32'h12345678, 32'h12345678};
      rv[1] = '{REG_PERIOD,  32'h00000000, 32'h00000000};
      rv[2] = '{REG_PATTERN, 32'hFFFFFFFF, 32'h03FFFFFF};
      rv[3] = '{REG_CONTROL, 32'hFFFFFFFC, 32'h00000000};
      rv[4] = '{REG_CONTROL, 32'h00000002, 32'h00000002};
      rv[5] = '{REG_CONTROL, 32'h00000000, 32'h00000000};

      for (int i = 0; i < 10; i++) begin
         n_pat  = nv[i].pat;
         n_dir  = nv[i].dir;
         n_mode = nv[i].mode;
         #1;
         check($sformatf("next_pat[%0d]", i), 32'(n_next_pat), 32'(nv[i].exp_pat));
         check($sformatf("next_dir[%0d]", i), 32'(n_next_dir), 32'(nv[i].exp_dir));
      end

      // 1. Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", 32'(m_chipselect), 32'd0);
      check("rst_wn", 32'(m_write_n), 32'd1);
      check("rst_wd", m_writedata, 32'd0);
      check("rst_pulse", 32'(step_pulse), 32'd0);
      check("rst_addr", 32'(m_address), 32'd0);
      reset = 1'b0;
      wr_total = 0;
      idle_cycles(1);
      bus_read(REG_PERIOD, rd);  check("rst_period", rd, 32'd50000000);
      bus_read(REG_STATUS, rd);  check("rst_status", rd, 32'd0);
      bus_read(REG_CONTROL, rd); check("rst_control", rd, 32'd0);
      bus_read(REG_PATTERN, rd); check("rst_pattern", rd, 32'd0);

      for (int i = 0; i < 6; i++) begin
         bus_write(rv[i].addr, rv[i].wdata);
         idle_cycles(2);
         bus_read(rv[i].addr, rd);
         check($sformatf("reg[%0d]", i), rd, rv[i].exp_rd);
      end
      bus_write(REG_STATUS, 32'hFFFFFFFF);
      idle_cycles(2);
      bus_read(REG_STATUS, rd);
      check("status_ro", rd, {16'(wr_total), 16'd0});

      // 2. Rotate-left at PERIOD=3
      bus_write(REG_PERIOD, 32'd3);
      clear_log();
      bus_write(REG_PATTERN, 32'h1);
      bus_write(REG_CONTROL, 32'h1);
      wait_writes("rot_count", 4, 60);
      if (wr_data.size() >= 4) begin
         check("rot_w0", wr_data[0], 32'h1);
         check("rot_w1", wr_data[1], 32'h2);
         check("rot_w2", wr_data[2], 32'h4);
         check("rot_w3", wr_data[3], 32'h8);
         check("rot_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
         check("rot_gap23", 32'(wr_cyc[3] - wr_cyc[2]), 32'd4);
      end
      bus_write(REG_CONTROL, 32'h0);
      idle_cycles(4);
      bus_read(REG_STATUS, rd);
      check("rot_busy", rd & 32'h1, 32'd0);
      check("rot_stepcnt", rd >> 16, 32'(wr_total));

      // 3. Rotate wrap of the top bit
      bus_write(REG_PERIOD, 32'd1);
      clear_log();
      bus_write(REG_PATTERN, 32'h2000000);
      bus_write(REG_CONTROL, 32'h1);
      wait_writes("wrap_count", 2, 40);
      if (wr_data.size() >= 2) begin
         check("wrap_w0", wr_data[0], 32'h2000000);
         check("wrap_w1", wr_data[1], 32'h0000001);
      end
      bus_write(REG_CONTROL, 32'h0);
      idle_cycles(4);

      // 4. Bounce reversal at the top edge
      clear_log();
      bus_write(REG_PATTERN, 32'h1000000);
      bus_write(REG_CONTROL, 32'h3);
      wait_writes("bnc_count", 4, 60);
      if (wr_data.size() >= 4) begin
         check("bnc_w0", wr_data[0], 32'h1000000);
         check("bnc_w1", wr_data[1], 32'h2000000);
         check("bnc_w2", wr_data[2], 32'h1000000);
         check("bnc_w3", wr_data[3], 32'h0800000);
      end
      bus_write(REG_CONTROL, 32'h0);
      idle_cycles(4);

      // 5. Stall with waitrequest, then reset mid-transfer
      bus_read(REG_STATUS, sc0);
      m_waitrequest = 1'b1;
      bus_write(REG_PATTERN, 32'h155);
      check("stall_cs0", 32'(m_chipselect), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall_cs[%0d]", i), 32'(m_chipselect), 32'd1);
         check($sformatf("stall_wd[%0d]", i), m_writedata, 32'h155);
         check($sformatf("stall_pulse[%0d]", i), 32'(step_pulse), 32'd0);
      end
      m_waitrequest = 1'b0;
      #1;
      check("accept_pulse", 32'(step_pulse), 32'd1);
      @(posedge clk);
      #1;
      check("after_pulse", 32'(step_pulse), 32'd0);
      check("after_cs", 32'(m_chipselect), 32'd0);
      bus_read(REG_STATUS, rd);
      check("stall_stepcnt", rd >> 16, ((sc0 >> 16) + 32'd1) & 32'hFFFF);

      m_waitrequest = 1'b1;
      bus_write(REG_PATTERN, 32'h3);
      check("pre_rst_cs", 32'(m_chipselect), 32'd1);
      reset = 1'b1;
      #1;
      check("async_rst_cs", 32'(m_chipselect), 32'd0);
      check("async_rst_wn", 32'(m_write_n), 32'd1);
      idle_cycles(2);
      reset = 1'b0;
      wr_total = 0;
      m_waitrequest = 1'b0;
      idle_cycles(1);
      bus_read(REG_PERIOD, rd);
      check("rst2_period", rd, 32'd50000000);

      // 6. PERIOD=0 steps every 2 cycles; disable during a stalled WRITE
      bus_write(REG_PERIOD, 32'd0);
      clear_log();
      bus_write(REG_PATTERN, 32'h1);
      bus_write(REG_CONTROL, 32'h1);
      wait_writes("p0_count", 4, 40);
      if (wr_data.size() >= 4) begin
         check("p0_w3", wr_data[3], 32'h8);
         check("p0_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd2);
         check("p0_gap23", 32'(wr_cyc[3] - wr_cyc[2]), 32'd2);
      end
      k = 0;
      while (!m_chipselect && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("p0_in_write", 32'(m_chipselect), 32'd1);
      m_waitrequest = 1'b1;
      bus_write(REG_CONTROL, 32'h0);
      check("dis_cs_held", 32'(m_chipselect), 32'd1);
      k = wr_total;
      m_waitrequest = 1'b0;
      @(posedge clk);
      #1;
      check("dis_completed", 32'(wr_total), 32'(k + 1));
      check("dis_cs_drop", 32'(m_chipselect), 32'd0);
      bus_read(REG_STATUS, rd);
      check("dis_busy", rd & 32'h1, 32'd0);

      // 7. PATTERN write while a transfer is stalled
      idle_cycles(2);
      clear_log();
      m_waitrequest = 1'b1;
      bus_write(REG_PATTERN, 32'hA);
      bus_write(REG_PATTERN, 32'h5);
      m_waitrequest = 1'b0;
      idle_cycles(5);
      check("pw_count", 32'(wr_data.size()), 32'd2);
      if (wr_data.size() >= 2) begin
         check("pw_w0", wr_data[0], 32'hA);
         check("pw_w1", wr_data[1], 32'h5);
         check("pw_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
      end
      check("pw_idle_cs", 32'(m_chipselect), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
